// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receive CRC scheduler: source codes, FSM encoding and
// the fixed-priority source picker.
package sent_rx_pkg;

    localparam int unsigned NUM_SRC                = 5;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

    localparam logic [2:0] SRC_FAST6 = 3'd0;
    localparam logic [2:0] SRC_FAST4 = 3'd1;
    localparam logic [2:0] SRC_FAST3 = 3'd2;
    localparam logic [2:0] SRC_ENH   = 3'd3;
    localparam logic [2:0] SRC_SHORT = 3'd4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStart  = 2'd1,
        StWait   = 2'd2,
        StReport = 2'd3
    } state_e;

    // Lowest source code wins; bit i of pend belongs to source code i.
    function automatic logic [2:0] pick_src(input logic [NUM_SRC-1:0] pend);
        logic [2:0] src;
        src = SRC_FAST6;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                src = 3'(i);
            end
        end
        return src;
    endfunction

endpackage

// File: rtl/sent_rx_fall_detect.sv
// Per-source falling-edge detector with a single-deep pending bit and overrun indication.
module sent_rx_fall_detect (
    input  logic clk_rx,
    input  logic reset,
    input  logic level_i,
    input  logic clr_i,
    output logic pending_o,
    output logic overrun_o
);

    logic prev_q;
    logic pending_q;
    logic pending_d;
    logic fall;

    assign fall = prev_q & ~level_i;

    // A fresh edge beats a same-cycle clear, so a request is never lost.
    always_comb begin
        pending_d = pending_q;
        if (fall) begin
            pending_d = 1'b1;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= level_i;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign overrun_o = fall & pending_q & ~clr_i;

endmodule

// File: rtl/sent_rx_crc_sched.sv
// Arbitrates CRC check requests from five SENT decoders onto one shared CRC checker and
// reports per-frame results, timeouts, overruns and a saturating CRC error count.
module sent_rx_crc_sched
    import sent_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_rx,
    input  logic             reset,
    input  logic             done_pre_data_fast6_i,
    input  logic             done_pre_data_fast4_i,
    input  logic             done_pre_data_fast3_i,
    input  logic             done_pre_data_enhanced_i,
    input  logic             done_pre_data_short_i,
    output logic             enable_crc_check_fast6_o,
    output logic             enable_crc_check_fast4_o,
    output logic             enable_crc_check_fast3_o,
    output logic             enable_crc_check_enhanced_o,
    output logic             enable_crc_check_serial_o,
    input  logic             crc_done_i,
    input  logic             crc_ok_i,
    input  logic             clear_status_i,
    output logic             busy_o,
    output logic             frame_ok_o,
    output logic             frame_err_o,
    output logic [2:0]       frame_src_o,
    output logic             overrun_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] crc_err_cnt_o
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [2:0]         src_q, src_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               ok_q, ok_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] ovr;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] en;
    logic               tmo_hit;

    assign level = {done_pre_data_short_i, done_pre_data_enhanced_i, done_pre_data_fast3_i,
                    done_pre_data_fast4_i, done_pre_data_fast6_i};

    // The winner's pending bit is retired while its start pulse is out.
    assign clr = (state_q == StStart) ? (NUM_SRC'(1) << src_q) : '0;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        sent_rx_fall_detect u_fall_detect (
            .clk_rx    (clk_rx),
            .reset     (reset),
            .level_i   (level[g]),
            .clr_i     (clr[g]),
            .pending_o (pend[g]),
            .overrun_o (ovr[g])
        );
    end

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|pend) state_d = StStart;
            StStart:  state_d = StWait;
            StWait:   if (crc_done_i || tmo_hit) state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        en          = '0;
        busy_o      = (state_q != StIdle);
        frame_ok_o  = 1'b0;
        frame_err_o = 1'b0;
        unique case (state_q)
            StStart:  en = NUM_SRC'(1) << src_q;
            StReport: begin
                frame_ok_o  = ok_q;
                frame_err_o = ~ok_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state; crc_done is only looked at in WAIT and beats a same-cycle timeout.
    always_comb begin
        src_d     = src_q;
        tmo_cnt_d = tmo_cnt_q;
        ok_d      = ok_q;
        overrun_d = overrun_q | (|ovr);
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: if (|pend) src_d = pick_src(pend);
            StStart: begin
                tmo_cnt_d = '0;
                ok_d      = 1'b0;
            end
            StWait: begin
                if (crc_done_i) begin
                    ok_d = crc_ok_i;
                    if (!crc_ok_i && (cnt_q != '1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    ok_d      = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (clear_status_i) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            src_q     <= 3'd0;
            tmo_cnt_q <= '0;
            ok_q      <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            src_q     <= src_d;
            tmo_cnt_q <= tmo_cnt_d;
            ok_q      <= ok_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign enable_crc_check_fast6_o    = en[SRC_FAST6];
    assign enable_crc_check_fast4_o    = en[SRC_FAST4];
    assign enable_crc_check_fast3_o    = en[SRC_FAST3];
    assign enable_crc_check_enhanced_o = en[SRC_ENH];
    assign enable_crc_check_serial_o   = en[SRC_SHORT];
    assign frame_src_o                 = src_q;
    assign overrun_o                   = overrun_q;
    assign timeout_o                   = timeout_q;
    assign crc_err_cnt_o               = cnt_q;

endmodule
